// File: rtl/sub_serial_8bit.sv
// Bit-serial LSB-first subtractor: o_diff = i_a - i_b - i_bin, o_done WIDTH cycles after start.
// i_start is ignored while o_busy; results hold until the next operation completes.
module sub_serial_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic             br_q, br_d, borrow_q, borrow_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_bit, br_next, start_ok;

  // The single full-subtractor cell, fed by the LSBs of the shifting operands.
  always_comb begin
    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    start_ok = i_start && (state_q != RUN);

    case (state_q)
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        br_d  = br_next;
        if (cnt_q == LAST) begin
          // Outputs only change on the edge entering DONE; br_q is the borrow into the MSB.
          state_d  = DONE;
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = br_next;
          ovf_d    = br_q ^ br_next;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start_ok) begin
      state_d = RUN;
      a_d     = i_a;
      b_d     = i_b;
      br_d    = i_bin;
      res_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_busy   = (state_q == RUN);
  assign o_done   = (state_q == DONE);
  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;
  assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_sub_serial_8bit.sv
// Directed and random checks of sub_serial_8bit against an arithmetic reference.
module tb_sub_serial_8bit;
  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst_n, i_start, i_bin;
  logic [W-1:0] i_a, i_b;
  logic         o_busy, o_done, o_borrow, o_ovf;
  logic [W-1:0] o_diff;

  int checks = 0;
  int failures = 0;

  sub_serial_8bit #(.WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_bin   (i_bin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_diff  (o_diff),
    .o_borrow(o_borrow),
    .o_ovf   (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned difference for result/borrow, signed range test for overflow.
  task automatic ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output logic [7:0] d, output logic bo, output logic ov);
    int r, sr;
    r  = int'(a) - int'(b) - int'(bin);
    sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = r[7:0];
    bo = (r < 0);
    ov = (sr < -128) || (sr > 127);
  endtask

  // Called at a negedge in IDLE; operands are scrambled during RUN to prove they were captured.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input string tag, input bit chk_busy);
    int lat;
    logic [7:0] ed;
    logic eb, eo;
    ref_sub(a, b, bin, ed, eb, eo);
    i_a = a; i_b = b; i_bin = bin; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    lat = 1;
    if (chk_busy) check({tag, "_busy"}, 32'(o_busy), 32'(1));
    while (!o_done && lat < 40) begin
      i_a = 8'($urandom); i_b = 8'($urandom); i_bin = 1'($urandom);
      @(negedge i_clk);
      lat++;
    end
    if (chk_busy) check({tag, "_latency"}, 32'(lat - 1), 32'(W));
    check({tag, "_diff"},   32'(o_diff),   32'(ed));
    check({tag, "_borrow"}, 32'(o_borrow), 32'(eb));
    check({tag, "_ovf"},    32'(o_ovf),    32'(eo));
    @(negedge i_clk);
    if (chk_busy) check({tag, "_done_width"}, 32'(o_done), 32'(0));
  endtask

  initial begin
    int t, t1, t2;
    bit seen;
    logic [7:0] ed;
    logic eb, eo;

    i_rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_bin = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_done", 32'(o_done), 32'(0));
    check("rst_outs", 32'({o_diff, o_borrow, o_ovf}), 32'(0));
    i_rst_n = 1'b1;
    @(negedge i_clk);

    do_op(8'h05, 8'h03, 1'b0, "d05_03", 1'b1);
    do_op(8'h00, 8'h01, 1'b0, "d00_01", 1'b1);
    do_op(8'h80, 8'h01, 1'b0, "d80_01", 1'b1);
    do_op(8'h10, 8'h0F, 1'b1, "d10_0F_b", 1'b1);
    do_op(8'h7F, 8'hFF, 1'b0, "d7F_FF", 1'b1);
    check("const_7F_FF", 32'({o_diff, o_borrow, o_ovf}), 32'({8'h80, 1'b1, 1'b1}));

    // Reset in the middle of RUN cycle 3.
    i_a = 8'h12; i_b = 8'h34; i_bin = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(o_busy), 32'(0));
    check("midrst_outs", 32'({o_done, o_diff, o_borrow, o_ovf}), 32'(0));
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'(0));
    do_op(8'hAA, 8'h55, 1'b0, "dAA_55", 1'b1);
    check("const_AA_55", 32'({o_diff, o_borrow, o_ovf}), 32'({8'h55, 1'b0, 1'b1}));

    // Back-to-back with i_start held high and operands changing during RUN.
    i_a = 8'h05; i_b = 8'h03; i_bin = 1'b0; i_start = 1'b1;
    t = 0;
    t1 = 0;
    do begin
      @(negedge i_clk);
      t++;
      if (!o_done) begin i_a = 8'($urandom); i_b = 8'($urandom); i_bin = 1'($urandom); end
    end while (!o_done && t < 40);
    t1 = t;
    check("b2b_first_diff", 32'({o_diff, o_borrow, o_ovf}), 32'({8'h02, 1'b0, 1'b0}));
    i_a = 8'h3C; i_b = 8'h5A; i_bin = 1'b1;
    do begin
      @(negedge i_clk);
      t++;
      if (t == t1 + 4) check("b2b_hold_during_run", 32'({o_busy, o_diff}), 32'({1'b1, 8'h02}));
      if (!o_done) begin i_a = 8'($urandom); i_b = 8'($urandom); i_bin = 1'($urandom); end
    end while (!o_done && t < t1 + 40);
    t2 = t;
    i_start = 1'b0;
    check("b2b_spacing", 32'(t2 - t1), 32'(W + 1));
    ref_sub(8'h3C, 8'h5A, 1'b1, ed, eb, eo);
    check("b2b_second", 32'({o_diff, o_borrow, o_ovf}), 32'({ed, eb, eo}));
    @(negedge i_clk);
    @(negedge i_clk);
    check("b2b_idle", 32'({o_busy, o_done}), 32'(0));

    for (int n = 0; n < 1000; n++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), "rand", (n % 100) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
